report_tx_scheduler: RTL
========================

# report_tx_scheduler

Shares one byte-wide UART transmitter between three external report sources and an internal heartbeat in the production-test bitstreams. Each source posts a one-byte payload with a single-cycle request. The scheduler holds at most one pending payload per source and grants the sources round-robin. For each grant it sends a two-byte frame {tag, payload} over a valid/ready handshake to the UART TX serializer.

## Interface
- HB_TICKS, default 24_000_000: heartbeat period in clk cycles (1 s at 24 MHz); 0 disables the heartbeat.
- TAG_BASE, default 8'h41: tag byte for source 0; the tag for source i is TAG_BASE + i.

- clk  in  1  system clock (HFOSC, 24 MHz).
- rst  in  1  reset; one clock, asynchronous, active-high.
- src_req  in  3  per-source request strobe, one cycle wide; bit i = source i (0 touch count, 1 pin test, 2 spare).
- src_data  in  24  payloads; source i uses bits [8i+7:8i], sampled in the cycle its req is high.
- ovr_clr  in  1  single-cycle pulse; clears overrun.
- tx_data  out  8  byte to serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the byte when tx_valid && tx_ready.
- busy  out  1  high while a frame is in flight (FSM not IDLE).
- overrun  out  4  sticky; bit i set when source i's pending payload was overwritten before being sent.
- frame_count  out  8  number of completed frames, wraps 255 -> 0.

## Operation
- Per-source state: pending[3:0] and payload[3:0][7:0]. Index 3 is the heartbeat.
- Posting a request (src_req[i] high, i ≤ 2):
  - pending[i] <= 1 and payload[i] <= src_data byte i.
  - If pending[i] was already 1 and it is not being granted this cycle, overrun[i] <= 1 and the new data replaces the old.
- Heartbeat:
  - 32-bit down-counter loaded with HB_TICKS-1; it reloads on reaching 0.
  - At 0 it sets pending[3] and loads payload[3] <= frame_count.
  - The same overrun rule applies to bit 3.
- Grant, performed only in IDLE when any pending bit is set:
  - Search starts at index (ptr+1) mod 4 and increments with wrap; the first pending index wins.
  - On grant: ptr <= winner, frame_tag <= TAG_BASE + winner, frame_data <= payload[winner], pending[winner] <= 0.
  - A request from the winning source in the grant cycle sets pending again with the new data; no overrun is recorded.
- FSM states:
  - IDLE: tx_valid=0; if any pending bit is set, grant and go to TAG.
  - TAG: tx_valid=1, tx_data=frame_tag; on tx_ready go to DATA.
  - DATA: tx_valid=1, tx_data=frame_data; on tx_ready, frame_count++ and go to IDLE.
- Handshake rules:
  - Once tx_valid rises, tx_valid and tx_data stay stable until the byte is accepted.
  - tx_valid never drops without acceptance.
- ovr_clr clears all overrun bits. A new overrun event in the same cycle wins, so that bit stays 1.
- Arithmetic:
  - The tag addition is 8-bit and wraps.
  - frame_count wraps 8-bit.
  - The heartbeat counter width is 32 bits; HB_TICKS must fit in it.

## Timing
- Reset values:
  - State IDLE; tx_valid=0; tx_data=8'h00; busy=0; overrun=0; frame_count=0.
  - pending=0; payloads=0; ptr=3, so source 0 is searched first.
  - Heartbeat counter = HB_TICKS-1.
- All outputs are registered.
- Latency, with src_req at cycle N and the scheduler IDLE:
  - pending is visible at N+1; grant happens at N+1.
  - tx_valid with the tag is high at N+2.
  - With tx_ready held high, the data byte is on at N+3 and tx_valid=0 at N+4.
- Back-to-back frames: minimum one IDLE cycle between frames (3 cycles per frame with tx_ready constantly high).
- busy is high in TAG and DATA, and low in IDLE.
- Reset asserted mid-frame: all state returns to reset values immediately. The partial frame and pending payloads are discarded, and tx_valid drops asynchronously.
- Heartbeat with HB_TICKS=1: pending[3] is set every cycle. A frame stream with continuous overrun[3] is legal.

## Test plan
- Single request: reset, src_req=3'b001, src_data[7:0]=8'h5A, tx_ready=1 -> tx_valid at cycle +2 with bytes 8'h41 then 8'h5A; frame_count=1; busy high for exactly 2 cycles.
- Simultaneous requests: src_req=3'b111 with payloads 11/22/33 and HB_TICKS=0 -> frames in order 41/11, 42/22, 43/33; overrun=0.
- Backpressure: tx_ready=0 for 10 cycles during TAG -> tx_valid and tx_data=8'h41 held constant for all 10 cycles; the frame completes after tx_ready=1.
- Overrun: two src_req[1] pulses (AA then BB) while a source-0 frame is stalled -> one frame 42/BB, overrun=4'b0010; ovr_clr -> overrun=0.
- Heartbeat: HB_TICKS=100, no requests -> frame 44/00 at cycle ~101, next frame 44/01 at ~201.
- Reset mid-frame: rst asserted in DATA -> tx_valid=0 immediately; after release frame_count=0 and no frame is emitted without a new request.

Source files
------------

// File: rtl/report_tx_scheduler.sv
// Round-robin scheduler that shares one UART byte stream between three report
// sources and a heartbeat, sending a {tag, payload} frame per grant.
module report_tx_scheduler #(
  parameter int unsigned HB_TICKS = 24_000_000,
  parameter logic [7:0]  TAG_BASE = 8'h41
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  src_req,
  input  logic [23:0] src_data,
  input  logic        ovr_clr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [3:0]  overrun,
  output logic [7:0]  frame_count
);

  // Handshake: a byte moves when tx_valid && tx_ready at a rising edge; once
  // tx_valid is high, tx_valid and tx_data hold until that transfer happens.

  typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

  localparam logic [31:0] HB_LOAD = 32'(HB_TICKS - 1);

  state_t      state, state_nxt;
  logic [3:0]  pending;
  logic [7:0]  payload [4];
  logic [1:0]  ptr;
  logic [7:0]  frame_data;
  logic [31:0] hb_cnt;
  logic        hb_fire;
  logic        found;
  logic        grant;
  logic [1:0]  winner;
  logic [3:0]  post;
  logic [7:0]  post_byte [4];
  logic [3:0]  ovr_evt;

  assign hb_fire = (HB_TICKS != 0) && (hb_cnt == 32'd0);

  // Search begins just after the last winner, wrapping through all four slots.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = 1; k <= 4; k++) begin
      if (!found && pending[ptr + 2'(k)]) begin
        found  = 1'b1;
        winner = ptr + 2'(k);
      end
    end
    grant = found && (state == IDLE);
  end

  always_comb begin
    post         = {hb_fire, src_req};
    post_byte[0] = src_data[7:0];
    post_byte[1] = src_data[15:8];
    post_byte[2] = src_data[23:16];
    post_byte[3] = frame_count;
    for (int i = 0; i < 4; i++) begin
      ovr_evt[i] = post[i] && pending[i] && !(grant && (winner == 2'(i)));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)    state_nxt = TAG;
      TAG:     if (tx_ready) state_nxt = DATA;
      DATA:    if (tx_ready) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      ptr         <= 2'd3;
      frame_data  <= 8'h00;
      frame_count <= 8'h00;
    end else begin
      state    <= state_nxt;
      tx_valid <= (state_nxt != IDLE);
      busy     <= (state_nxt != IDLE);
      if (grant) begin
        tx_data    <= TAG_BASE + {6'd0, winner};
        ptr        <= winner;
        frame_data <= payload[winner];
      end else if (state == TAG && tx_ready) begin
        tx_data <= frame_data;
      end
      if (state == DATA && tx_ready) frame_count <= frame_count + 8'd1;
    end
  end

  // A post in the grant cycle re-arms the winner, so posting takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 4'd0;
      overrun <= 4'd0;
      for (int i = 0; i < 4; i++) payload[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (post[i]) begin
          pending[i] <= 1'b1;
          payload[i] <= post_byte[i];
        end else if (grant && (winner == 2'(i))) begin
          pending[i] <= 1'b0;
        end
      end
      overrun <= (ovr_clr ? 4'd0 : overrun) | ovr_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt <= HB_LOAD;
    end else if (HB_TICKS != 0) begin
      hb_cnt <= (hb_cnt == 32'd0) ? HB_LOAD : hb_cnt - 32'd1;
    end
  end

endmodule
